dual_port_byte_ram: RTL and testbench
=====================================

Name: dual_port_byte_ram

Overview:
- Clocked, parametrised successor to the processor's combinational byte-addressed memory.
- Port A is a read-only instruction-fetch port; port B is a load/store data port with byte-lane write enables.
- Both ports are fully pipelined (one request per cycle) with a configurable read latency, explicit response valids and an out-of-range error flag.
- Sits between the fetch/memory pipeline stages and the shared unified memory array.

Parameters:
- DEPTH_BYTES, 4096: number of byte locations; must be a power of two, at least 16.
- DATA_BYTES, 4: bytes per word; data width is 8*DATA_BYTES.
- READ_LATENCY, 1: cycles from accepted request to response valid; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  port A read request
- a_addr  in  32  port A byte address
- a_rvalid  out  1  port A response valid
- a_rdata  out  8*DATA_BYTES  port A read data
- a_err  out  1  port A out-of-range flag, qualified by a_rvalid
- b_req  in  1  port B request
- b_we  in  1  1 = write, 0 = read
- b_be  in  DATA_BYTES  byte-lane write enables; bit i covers byte at b_addr+i
- b_addr  in  32  port B byte address
- b_wdata  in  8*DATA_BYTES  write data
- b_rvalid  out  1  port B response valid (reads and writes)
- b_rdata  out  8*DATA_BYTES  port B read data; 0 for writes
- b_err  out  1  port B out-of-range flag, qualified by b_rvalid

Behaviour:
- Byte order is little-endian: data bits [8i+7:8i] correspond to byte address addr+i.
- Requests are always accepted; there is no backpressure. A request presented on edge N produces rvalid=1 for exactly one cycle after edge N+READ_LATENCY-1.
  - With READ_LATENCY=1 the response is visible in the cycle following the request.
  - Back-to-back requests give back-to-back responses in request order.
- Range rule: an access is in range iff addr + DATA_BYTES <= DEPTH_BYTES (full 32-bit compare, no wrap).
  - Out-of-range read: rdata=0 and err=1 with the response.
  - Out-of-range write: no byte modified; b_err=1 with the response.
- Writes commit at the request edge, only for lanes with b_be[i]=1. b_be=0 is a legal no-op and still returns a response with err=0.
- Port B reads of an address written earlier return the written data, including a read issued the cycle after the write.
- Same-edge collision (port A reads a byte that port B writes on the same edge): port A returns the OLD byte (read-before-write) unless MEM_FWD_EN is defined.
- Unaligned addresses are legal; each byte is addressed independently.
- Reset (asynchronous):
  - a_rvalid, b_rvalid, a_err and b_err go to 0; a_rdata and b_rdata go to 0.
  - The latency pipeline is flushed, so in-flight responses are dropped and never emitted.
  - Memory contents are NOT cleared.
  - Requests are ignored while reset is high. The first request after deassertion behaves normally.
- Memory array contents are undefined at power-up (simulation X).

Optional Feature:
- Macro MEM_FWD_EN.
- Defined: on a same-edge collision, port A read data takes the new b_wdata bytes for the colliding, enabled lanes (write-first). Non-colliding lanes return stored data.
- Undefined: read-before-write as stated in Behaviour.
- Port B behaviour is identical in both builds.

Test Plan:
- READ_LATENCY=1: B write addr 0x10, data 0xDEADBEEF, be=1111; next cycle B read 0x10 -> b_rvalid next cycle with b_rdata=0xDEADBEEF, b_err=0; A read 0x11 -> a_rdata=0x??DEADBE with top byte = prior mem[0x14].
- Byte enables: write 0x11223344 at 0x20 be=1111, then 0xAABBCCDD be=0101 -> read 0x20 returns 0x11BB33DD.
- Range: DEPTH_BYTES=4096, B write at 0xFFD -> no change, b_err=1. A read 0xFFC -> err=0. A read 0x1000 -> a_rdata=0, a_err=1.
- Collision: mem[0x40..0x43]=0x00000000; same edge A read 0x40 and B write 0x40 0x55667788 be=1111 -> a_rdata=0x00000000 without MEM_FWD_EN, 0x55667788 with it.
- READ_LATENCY=3 streaming: A reads 0x0, 0x4, 0x8 on consecutive cycles -> a_rvalid high for 3 consecutive cycles starting 3 cycles after the first request, in order.
- Reset mid-flight: READ_LATENCY=3, B read issued, reset pulsed the next cycle -> no b_rvalid ever emitted; earlier-written data is still readable after reset.

Source files
------------

// File: rtl/dual_port_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_byte_ram
// Description : Byte-addressed unified memory with a read-only fetch port (A)
//               and a load/store port (B) with byte-lane write enables.
//               Both ports are fully pipelined with READ_LATENCY cycles from
//               request to response, little-endian byte order, and an
//               out-of-range error flag returned with each response.
//               Optional build macro: MEM_FWD_EN (port A write-first on a
//               same-edge collision with a port B write; default is
//               read-before-write).
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_byte_ram #(
  parameter int DEPTH_BYTES  = 4096,
  parameter int DATA_BYTES   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_req,
  input  logic [31:0]             a_addr,
  output logic                    a_rvalid,
  output logic [8*DATA_BYTES-1:0] a_rdata,
  output logic                    a_err,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [DATA_BYTES-1:0]   b_be,
  input  logic [31:0]             b_addr,
  input  logic [8*DATA_BYTES-1:0] b_wdata,
  output logic                    b_rvalid,
  output logic [8*DATA_BYTES-1:0] b_rdata,
  output logic                    b_err
);

  localparam int          c_AW    = $clog2(DEPTH_BYTES);
  localparam int          c_DW    = 8 * DATA_BYTES;
  localparam logic [32:0] c_DEPTH = 33'(DEPTH_BYTES);
  localparam logic [32:0] c_NB    = 33'(DATA_BYTES);

  // Storage: one byte per location, never reset.
  logic [7:0] r_mem [DEPTH_BYTES];

  // Per-lane byte indices; only meaningful when the access is in range.
  logic [c_AW-1:0] w_a_idx [DATA_BYTES];
  logic [c_AW-1:0] w_b_idx [DATA_BYTES];

  logic            w_a_ok;
  logic            w_b_ok;
  logic            w_b_wr;
  logic [c_DW-1:0] w_a_rd;
  logic [c_DW-1:0] w_b_rd;
  logic [c_DW-1:0] w_a_data;
  logic [c_DW-1:0] w_b_data;

  // Response pipelines; the last stage drives the outputs.
  logic            r_a_vld  [READ_LATENCY];
  logic            r_a_erq  [READ_LATENCY];
  logic [c_DW-1:0] r_a_dat  [READ_LATENCY];
  logic            r_b_vld  [READ_LATENCY];
  logic            r_b_erq  [READ_LATENCY];
  logic [c_DW-1:0] r_b_dat  [READ_LATENCY];

  // Full-width range check: addr + DATA_BYTES <= DEPTH_BYTES, no 32-bit wrap.
  always_comb begin
    w_a_ok = (({1'b0, a_addr} + c_NB) <= c_DEPTH);
    w_b_ok = (({1'b0, b_addr} + c_NB) <= c_DEPTH);
    w_b_wr = b_req & b_we & w_b_ok;
  end

  // Lane i addresses byte addr+i.
  always_comb begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      w_a_idx[i] = a_addr[c_AW-1:0] + c_AW'(i);
      w_b_idx[i] = b_addr[c_AW-1:0] + c_AW'(i);
    end
  end

  // Read both ports from the stored (pre-write) array, optionally forwarding
  // colliding port B write bytes into port A.
  always_comb begin
    w_a_rd = '0;
    w_b_rd = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      w_a_rd[8*i +: 8] = r_mem[w_a_idx[i]];
      w_b_rd[8*i +: 8] = r_mem[w_b_idx[i]];
`ifdef MEM_FWD_EN
      for (int j = 0; j < DATA_BYTES; j++) begin
        if (w_b_wr && b_be[j] && (w_b_idx[j] == w_a_idx[i])) begin
          w_a_rd[8*i +: 8] = b_wdata[8*j +: 8];
        end
      end
`endif
    end
    w_a_data = w_a_ok ? w_a_rd : '0;
    w_b_data = (w_b_ok && !b_we) ? w_b_rd : '0;
  end

  // Response pipelines plus write commit; reset flushes in-flight responses
  // and blocks writes but leaves the array contents alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_a_vld[k] <= 1'b0;
        r_a_erq[k] <= 1'b0;
        r_a_dat[k] <= '0;
        r_b_vld[k] <= 1'b0;
        r_b_erq[k] <= 1'b0;
        r_b_dat[k] <= '0;
      end
    end else begin
      r_a_vld[0] <= a_req;
      r_a_erq[0] <= a_req & ~w_a_ok;
      r_a_dat[0] <= a_req ? w_a_data : '0;
      r_b_vld[0] <= b_req;
      r_b_erq[0] <= b_req & ~w_b_ok;
      r_b_dat[0] <= b_req ? w_b_data : '0;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_a_vld[k] <= r_a_vld[k-1];
        r_a_erq[k] <= r_a_erq[k-1];
        r_a_dat[k] <= r_a_dat[k-1];
        r_b_vld[k] <= r_b_vld[k-1];
        r_b_erq[k] <= r_b_erq[k-1];
        r_b_dat[k] <= r_b_dat[k-1];
      end
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (w_b_wr && b_be[i]) begin
          r_mem[w_b_idx[i]] <= b_wdata[8*i +: 8];
        end
      end
    end
  end

  assign a_rvalid = r_a_vld[READ_LATENCY-1];
  assign a_err    = r_a_erq[READ_LATENCY-1];
  assign a_rdata  = r_a_dat[READ_LATENCY-1];
  assign b_rvalid = r_b_vld[READ_LATENCY-1];
  assign b_err    = r_b_erq[READ_LATENCY-1];
  assign b_rdata  = r_b_dat[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_dual_port_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_port_byte_ram
// Description : Self-checking bench for dual_port_byte_ram. A latency-1
//               instance is driven from a directed vector table; a latency-3
//               instance covers streaming and reset-while-in-flight.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_byte_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Latency-1 instance signals
  logic        rst1;
  logic        a1_req, a1_rvalid, a1_err;
  logic [31:0] a1_addr, a1_rdata;
  logic        b1_req, b1_we, b1_rvalid, b1_err;
  logic [3:0]  b1_be;
  logic [31:0] b1_addr, b1_wdata, b1_rdata;

  // Latency-3 instance signals
  logic        rst3;
  logic        a3_req, a3_rvalid, a3_err;
  logic [31:0] a3_addr, a3_rdata;
  logic        b3_req, b3_we, b3_rvalid, b3_err;
  logic [3:0]  b3_be;
  logic [31:0] b3_addr, b3_wdata, b3_rdata;

  dual_port_byte_ram #(.DEPTH_BYTES(4096), .DATA_BYTES(4), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst1),
    .a_req(a1_req), .a_addr(a1_addr), .a_rvalid(a1_rvalid), .a_rdata(a1_rdata), .a_err(a1_err),
    .b_req(b1_req), .b_we(b1_we), .b_be(b1_be), .b_addr(b1_addr), .b_wdata(b1_wdata),
    .b_rvalid(b1_rvalid), .b_rdata(b1_rdata), .b_err(b1_err)
  );

  dual_port_byte_ram #(.DEPTH_BYTES(4096), .DATA_BYTES(4), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(rst3),
    .a_req(a3_req), .a_addr(a3_addr), .a_rvalid(a3_rvalid), .a_rdata(a3_rdata), .a_err(a3_err),
    .b_req(b3_req), .b_we(b3_we), .b_be(b3_be), .b_addr(b3_addr), .b_wdata(b3_wdata),
    .b_rvalid(b3_rvalid), .b_rdata(b3_rdata), .b_err(b3_err)
  );

  typedef struct {
    logic        a_req;
    logic [31:0] a_addr;
    logic        b_req;
    logic        b_we;
    logic [3:0]  b_be;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [31:0] ea_data;
    logic        ea_err;
    logic [31:0] eb_data;
    logic        eb_err;
  } vec_t;

  localparam int NV = 18;
  vec_t v [NV];

  function automatic vec_t mk(input logic ar, input logic [31:0] aa,
                              input logic br, input logic bw, input logic [3:0] be,
                              input logic [31:0] ba, input logic [31:0] bd,
                              input logic [31:0] ead, input logic eae,
                              input logic [31:0] ebd, input logic ebe);
    vec_t t;
    t.a_req = ar; t.a_addr = aa;
    t.b_req = br; t.b_we = bw; t.b_be = be; t.b_addr = ba; t.b_wdata = bd;
    t.ea_data = ead; t.ea_err = eae; t.eb_data = ebd; t.eb_err = ebe;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  logic [31:0] coll_exp;

  initial begin
`ifdef MEM_FWD_EN
    coll_exp = 32'h5566_7788;
`else
    coll_exp = 32'h0000_0000;
`endif
    //        a_req a_addr        b_req we be     b_addr        b_wdata        ea_data        eae  eb_data        ebe
    v[0]  = mk(0, 32'h0,        1, 1, 4'b0001, 32'h14,       32'h0000_00A5, 32'h0,        0, 32'h0,        0);
    v[1]  = mk(0, 32'h0,        1, 1, 4'b1111, 32'h10,       32'hDEAD_BEEF, 32'h0,        0, 32'h0,        0);
    v[2]  = mk(1, 32'h11,       1, 0, 4'b0000, 32'h10,       32'h0,         32'hA5DE_ADBE, 0, 32'hDEAD_BEEF, 0);
    v[3]  = mk(0, 32'h0,        1, 1, 4'b1111, 32'h20,       32'h1122_3344, 32'h0,        0, 32'h0,        0);
    v[4]  = mk(0, 32'h0,        1, 1, 4'b0101, 32'h20,       32'hAABB_CCDD, 32'h0,        0, 32'h0,        0);
    v[5]  = mk(0, 32'h0,        1, 0, 4'b0000, 32'h20,       32'h0,         32'h0,        0, 32'h11BB_33DD, 0);
    v[6]  = mk(0, 32'h0,        1, 1, 4'b1111, 32'hFFC,      32'h0102_0304, 32'h0,        0, 32'h0,        0);
    v[7]  = mk(0, 32'h0,        1, 1, 4'b1111, 32'hFFD,      32'hFFFF_FFFF, 32'h0,        0, 32'h0,        1);
    v[8]  = mk(1, 32'hFFC,      1, 0, 4'b0000, 32'hFFC,      32'h0,         32'h0102_0304, 0, 32'h0102_0304, 0);
    v[9]  = mk(1, 32'h1000,     1, 0, 4'b0000, 32'hFFFF_FFFE, 32'h0,        32'h0,        1, 32'h0,        1);
    v[10] = mk(1, 32'hFFD,      0, 0, 4'b0000, 32'h0,        32'h0,         32'h0,        1, 32'h0,        0);
    v[11] = mk(0, 32'h0,        1, 1, 4'b1111, 32'h30,       32'h1234_5678, 32'h0,        0, 32'h0,        0);
    v[12] = mk(0, 32'h0,        1, 1, 4'b0000, 32'h30,       32'hFFFF_FFFF, 32'h0,        0, 32'h0,        0);
    v[13] = mk(0, 32'h0,        1, 0, 4'b0000, 32'h30,       32'h0,         32'h0,        0, 32'h1234_5678, 0);
    v[14] = mk(0, 32'h0,        1, 1, 4'b1111, 32'h40,       32'h0000_0000, 32'h0,        0, 32'h0,        0);
    v[15] = mk(1, 32'h40,       1, 1, 4'b1111, 32'h40,       32'h5566_7788, coll_exp,     0, 32'h0,        0);
    v[16] = mk(1, 32'h40,       1, 0, 4'b0000, 32'h40,       32'h0,         32'h5566_7788, 0, 32'h5566_7788, 0);
    v[17] = mk(0, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,         32'h0,        0, 32'h0,        0);

    rst1 = 1'b1; rst3 = 1'b1;
    a1_req = 0; a1_addr = 0; b1_req = 0; b1_we = 0; b1_be = 0; b1_addr = 0; b1_wdata = 0;
    a3_req = 0; a3_addr = 0; b3_req = 0; b3_we = 0; b3_be = 0; b3_addr = 0; b3_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset a_rvalid", {31'b0, a1_rvalid}, 32'h0);
    chk("reset b_rvalid", {31'b0, b1_rvalid}, 32'h0);
    chk("reset a_err/b_err", {30'b0, a1_err, b1_err}, 32'h0);
    chk("reset a_rdata", a1_rdata, 32'h0);
    chk("reset b_rdata", b1_rdata, 32'h0);
    chk("reset l3 rvalids", {30'b0, a3_rvalid, b3_rvalid}, 32'h0);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven latency-1 vectors: drive, one edge, check response.
    for (int k = 0; k < NV; k++) begin
      a1_req = v[k].a_req; a1_addr = v[k].a_addr;
      b1_req = v[k].b_req; b1_we = v[k].b_we; b1_be = v[k].b_be;
      b1_addr = v[k].b_addr; b1_wdata = v[k].b_wdata;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d a_rvalid", k), {31'b0, a1_rvalid}, {31'b0, v[k].a_req});
      chk($sformatf("v%0d b_rvalid", k), {31'b0, b1_rvalid}, {31'b0, v[k].b_req});
      if (v[k].a_req) begin
        chk($sformatf("v%0d a_rdata", k), a1_rdata, v[k].ea_data);
        chk($sformatf("v%0d a_err", k), {31'b0, a1_err}, {31'b0, v[k].ea_err});
      end
      if (v[k].b_req) begin
        chk($sformatf("v%0d b_rdata", k), b1_rdata, v[k].eb_data);
        chk($sformatf("v%0d b_err", k), {31'b0, b1_err}, {31'b0, v[k].eb_err});
      end
    end
    a1_req = 0; b1_req = 0;

    // Latency-3: preload three words through port B.
    for (int i = 0; i < 3; i++) begin
      b3_req = 1; b3_we = 1; b3_be = 4'hF;
      b3_addr = 32'(4 * i); b3_wdata = 32'hCAFE_0001 + 32'(i);
      @(posedge clk);
      #1;
    end
    b3_req = 0; b3_we = 0;
    repeat (4) @(posedge clk);
    #1;

    // Latency-3 streaming: three back-to-back A reads.
    for (int i = 0; i < 6; i++) begin
      a3_req  = (i < 3);
      a3_addr = 32'(4 * i);
      @(posedge clk);
      #1;
      if (i < 2) begin
        chk($sformatf("l3 stream c%0d a_rvalid", i), {31'b0, a3_rvalid}, 32'h0);
      end else if (i < 5) begin
        chk($sformatf("l3 stream c%0d a_rvalid", i), {31'b0, a3_rvalid}, 32'h1);
        chk($sformatf("l3 stream c%0d a_rdata", i), a3_rdata, 32'hCAFE_0001 + 32'(i - 2));
        chk($sformatf("l3 stream c%0d a_err", i), {31'b0, a3_err}, 32'h0);
      end else begin
        chk($sformatf("l3 stream c%0d a_rvalid", i), {31'b0, a3_rvalid}, 32'h0);
      end
    end
    a3_req = 0;
    repeat (2) @(posedge clk);
    #1;

    // Latency-3: B read in flight, reset pulsed the following cycle.
    b3_req = 1; b3_we = 0; b3_be = 0; b3_addr = 32'h4;
    @(posedge clk);
    #1;
    b3_req = 0;
    @(negedge clk);
    rst3 = 1'b1;
    #1;
    chk("l3 reset b_rvalid", {31'b0, b3_rvalid}, 32'h0);
    @(negedge clk);
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("l3 flushed c%0d b_rvalid", i), {31'b0, b3_rvalid}, 32'h0);
    end

    // Contents survive reset; first request after reset behaves normally.
    b3_req = 1; b3_we = 0; b3_addr = 32'h4;
    @(posedge clk);
    #1;
    b3_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("l3 post-reset b_rvalid", {31'b0, b3_rvalid}, 32'h1);
    chk("l3 post-reset b_rdata", b3_rdata, 32'hCAFE_0002);
    chk("l3 post-reset b_err", {31'b0, b3_err}, 32'h0);
    @(posedge clk);
    #1;
    chk("l3 post-reset single pulse", {31'b0, b3_rvalid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
